cmd_seq_player: RTL and testbench
=================================

Name: cmd_seq_player

Overview:
Synthesizable command-sequence engine that drives the RemoteComm host interface. It replays a loadable list of 16-bit Knight commands (calibrate 0x2000, moves, tours). For each command it waits for the response byte, checks for positive ack, then inserts a programmable settle gap before the next command. It generalises the single calibrate-then-wait bring-up flow to N commands, with nack/timeout detection, abort, and pass/fail reporting. It is used in simulation benches and on the FPGA bring-up build.

Parameters:
NUM_CMDS, 8, depth of the command store (>=1)
CMD_W, 16, command width
RESP_W, 8, response width
ACK_VAL, 8'hA5, response value treated as positive ack
TIMEOUT_CLKS, 24'd10_000_000, max clocks from snd_cmd pulse to resp_rdy
GAP_CLKS, 18'd200_000, settle clocks after each ack before next command (0 = no gap)
IDX_W, $clog2(NUM_CMDS+1), index/count width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ld_en  in  1  write ld_data into store at ld_addr (ignored while busy)
ld_addr  in  IDX_W  store write address (>= NUM_CMDS ignored)
ld_data  in  CMD_W  command word to store
num_cmds  in  IDX_W  commands to play, sampled on start, saturated to NUM_CMDS
start  in  1  begin playback (sampled only in IDLE)
abort  in  1  terminate playback
cmd  out  CMD_W  command to RemoteComm
snd_cmd  out  1  one-cycle send strobe to RemoteComm
cmd_snt  in  1  RemoteComm finished transmitting
resp_rdy  in  1  RemoteComm response valid (single-cycle)
resp  in  RESP_W  response byte
busy  out  1  high from SEND through GAP
done  out  1  one-cycle pulse at end of playback
pass  out  1  sticky result, valid after done
fail_code  out  2  00 none, 01 nack, 10 timeout, 11 abort
fail_idx  out  IDX_W  index of failing command
cmd_idx  out  IDX_W  index of the command currently in progress

Behaviour:
- Reset (async, rst_n low): state IDLE. cmd=0, snd_cmd=0, busy=0, done=0, pass=0, fail_code=00, fail_idx=0, cmd_idx=0, all counters 0. Store contents are undefined after reset; a bench must load them.
- Store: NUM_CMDS x CMD_W registers with a synchronous write. ld_en is honoured only in IDLE and DONE.
- States: IDLE, SEND, WAIT_SNT, WAIT_RESP, GAP, DONE.
- IDLE, start=1: latch the effective count n = min(num_cmds, NUM_CMDS). Clear pass, fail_code and fail_idx. Set cmd_idx=0.
  - If n==0: go to DONE with pass=1.
  - Otherwise go to SEND.
- SEND: lasts exactly one cycle. The registered outputs are cmd=store[cmd_idx] and snd_cmd=1. Load the timeout counter, then go to WAIT_SNT. Latency from start sampled to snd_cmd high is 1 cycle.
- cmd is held stable from SEND until the state leaves WAIT_RESP.
- WAIT_SNT: on cmd_snt go to WAIT_RESP. If resp_rdy arrives here, it is evaluated exactly as in WAIT_RESP.
- WAIT_RESP: on resp_rdy:
  - resp==ACK_VAL: if cmd_idx==n-1, go to DONE with pass=1. Otherwise go to GAP and load the gap counter.
  - Any other value: go to DONE with fail_code=01 and fail_idx=cmd_idx.
- Timeout: the counter runs through WAIT_SNT and WAIT_RESP. When it has counted TIMEOUT_CLKS cycles after the snd_cmd cycle without resp_rdy, go to DONE with fail_code=10. If resp_rdy arrives in the expiry cycle, the response wins.
- GAP: count GAP_CLKS cycles. On expiry, increment cmd_idx and go to SEND. GAP_CLKS=0 goes to SEND on the next cycle.
- abort: checked in any busy state, with priority over every other event that cycle. Go to DONE with fail_code=11 and fail_idx=cmd_idx.
  - No further snd_cmd is issued.
  - A resp_rdy arriving later is ignored.
  - abort in IDLE or DONE has no effect.
- DONE: done=1 for exactly one cycle (on entry), busy=0, then go to IDLE. pass, fail_code and fail_idx hold until the next start.
- start while busy is ignored.
- cmd_snt or resp_rdy arriving in IDLE, GAP or DONE is ignored.
- busy=1 in SEND, WAIT_SNT, WAIT_RESP and GAP.
- Reset asserted mid-playback returns all outputs to reset values immediately. No snd_cmd is issued after rst_n is deasserted until a new start.

Test Plan:
1. Load [0]=0x2000, num_cmds=1, start; the model acks 0xA5 -> exactly one snd_cmd with cmd=0x2000, done pulse, pass=1, fail_code=00.
2. Load 0x2000, 0x4001, 0x6002, GAP_CLKS=100, n=3, all acked -> three snd_cmd pulses, each ≥100 clocks after the previous resp_rdy, in order. Then pass=1 and cmd_idx=2.
3. n=3, second response 0x5A -> done with pass=0, fail_code=01, fail_idx=1. The third command is never sent.
4. TIMEOUT_CLKS=1000, resp_rdy withheld -> done exactly 1000 cycles after the snd_cmd cycle, fail_code=10. resp_rdy in the expiry cycle instead gives pass.
5. abort asserted in GAP after the first ack (n=3) -> done next cycle, fail_code=11, fail_idx=0, no further snd_cmd. A late resp_rdy is ignored.
6. n=0 start -> done 1 cycle later with pass=1 and no snd_cmd. rst_n pulsed low during WAIT_RESP -> all outputs 0 asynchronously, and the block stays IDLE afterwards.

Source files
------------

// File: rtl/cmd_seq_player.sv
// cmd_seq_player: replays a loaded list of Knight commands to the RemoteComm
// host interface. For each command: strobe it out, wait for the response
// byte, check it against ACK_VAL, then hold a settle gap before the next one.
// A nack, a missing response (timeout) or an abort ends playback early. The
// result is reported with a one-cycle done pulse and sticky pass/fail fields.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   ld_en/addr/data    command store write port (IDLE/DONE only)
//   num_cmds, start    playback length (saturated to NUM_CMDS) and go
//   abort              terminate playback from any busy state
//   cmd, snd_cmd       command word and one-cycle send strobe to RemoteComm
//   cmd_snt            RemoteComm finished transmitting
//   resp_rdy, resp     single-cycle response strobe and byte
//   busy, done, pass   status; fail_code 00 none/01 nack/10 timeout/11 abort
//   fail_idx, cmd_idx  failing command index, command in progress
module cmd_seq_player #(
  parameter int                NUM_CMDS     = 8,
  parameter int                CMD_W        = 16,
  parameter int                RESP_W       = 8,
  parameter logic [RESP_W-1:0] ACK_VAL      = 8'hA5,
  parameter logic [23:0]       TIMEOUT_CLKS = 24'd10_000_000,
  parameter logic [17:0]       GAP_CLKS     = 18'd200_000,
  parameter int                IDX_W        = $clog2(NUM_CMDS+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_en,
  input  logic [IDX_W-1:0]  ld_addr,
  input  logic [CMD_W-1:0]  ld_data,
  input  logic [IDX_W-1:0]  num_cmds,
  input  logic              start,
  input  logic              abort,
  output logic [CMD_W-1:0]  cmd,
  output logic              snd_cmd,
  input  logic              cmd_snt,
  input  logic              resp_rdy,
  input  logic [RESP_W-1:0] resp,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_code,
  output logic [IDX_W-1:0]  fail_idx,
  output logic [IDX_W-1:0]  cmd_idx
);

  // Store address width; at least one bit so NUM_CMDS=1 still has a port.
  localparam int               AW    = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1;
  localparam logic [IDX_W-1:0] N_MAX = IDX_W'(NUM_CMDS);

  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_NACK  = 2'b01;
  localparam logic [1:0] FC_TMO   = 2'b10;
  localparam logic [1:0] FC_ABORT = 2'b11;

  typedef enum logic [2:0] {IDLE, SEND, WAIT_SNT, WAIT_RESP, GAP, DONE} state_t;

  state_t           state;
  logic [CMD_W-1:0] store [2**AW];
  logic [IDX_W-1:0] n_lat;
  logic [IDX_W-1:0] n_eff;
  logic [IDX_W-1:0] idx_nxt;
  logic             last;
  logic [23:0]      tmo_cnt;
  logic [17:0]      gap_cnt;

  assign n_eff   = (num_cmds > N_MAX) ? N_MAX : num_cmds;
  assign idx_nxt = cmd_idx + IDX_W'(1);
  assign last    = (idx_nxt == n_lat);

  // Store has no reset: contents are undefined until loaded. Out-of-range
  // addresses are dropped so they cannot alias onto a real entry.
  always_ff @(posedge clk) begin
    if (ld_en && (state == IDLE || state == DONE) && (ld_addr < N_MAX))
      store[ld_addr[AW-1:0]] <= ld_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd       <= '0;
      snd_cmd   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_code <= FC_NONE;
      fail_idx  <= '0;
      cmd_idx   <= '0;
      n_lat     <= '0;
      tmo_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      snd_cmd <= 1'b0;
      done    <= 1'b0;
      // abort outranks every other event in a busy state
      if (abort && (state inside {SEND, WAIT_SNT, WAIT_RESP, GAP})) begin
        state     <= DONE;
        busy      <= 1'b0;
        done      <= 1'b1;
        pass      <= 1'b0;
        fail_code <= FC_ABORT;
        fail_idx  <= cmd_idx;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              n_lat     <= n_eff;
              pass      <= 1'b0;
              fail_code <= FC_NONE;
              fail_idx  <= '0;
              cmd_idx   <= '0;
              if (n_eff == '0) begin
                state <= DONE;
                done  <= 1'b1;
                pass  <= 1'b1;
              end else begin
                // outputs for SEND are registered on entry
                state   <= SEND;
                busy    <= 1'b1;
                snd_cmd <= 1'b1;
                cmd     <= store[AW'(0)];
              end
            end
          end
          SEND: begin
            // expiry is flagged at 1 so DONE lands TIMEOUT_CLKS after SEND
            tmo_cnt <= TIMEOUT_CLKS - 24'd1;
            state   <= WAIT_SNT;
          end
          WAIT_SNT, WAIT_RESP: begin
            // an early response is accepted even before cmd_snt, and it
            // beats a timeout expiring in the same cycle
            if (resp_rdy) begin
              if (resp == ACK_VAL) begin
                if (last) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= 1'b1;
                end else begin
                  state   <= GAP;
                  gap_cnt <= GAP_CLKS;
                end
              end else begin
                state     <= DONE;
                busy      <= 1'b0;
                done      <= 1'b1;
                fail_code <= FC_NACK;
                fail_idx  <= cmd_idx;
              end
            end else if (tmo_cnt <= 24'd1) begin
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              fail_code <= FC_TMO;
              fail_idx  <= cmd_idx;
            end else begin
              tmo_cnt <= tmo_cnt - 24'd1;
              if (state == WAIT_SNT && cmd_snt)
                state <= WAIT_RESP;
            end
          end
          GAP: begin
            // GAP always takes at least one cycle; 0 and 1 behave alike
            if (gap_cnt <= 18'd1) begin
              cmd_idx <= idx_nxt;
              state   <= SEND;
              snd_cmd <= 1'b1;
              cmd     <= store[idx_nxt[AW-1:0]];
            end else begin
              gap_cnt <= gap_cnt - 18'd1;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmd_seq_player.sv
// Directed bench for cmd_seq_player: a table of playback scenarios driven by
// a small RemoteComm responder, plus hand sequences for timeout latency,
// response-in-expiry-cycle, abort, empty playback and mid-run reset.
module tb_cmd_seq_player;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          ld_en = 1'b0;
  logic [IW-1:0] ld_addr = '0;
  logic [15:0]   ld_data = '0;
  logic [IW-1:0] num_cmds = '0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          cmd_snt = 1'b0;
  logic          resp_rdy = 1'b0;
  logic [7:0]    resp = '0;
  logic [15:0]   cmd;
  logic          snd_cmd, busy, done, pass;
  logic [1:0]    fail_code;
  logic [IW-1:0] fail_idx, cmd_idx;

  int checks = 0;
  int errors = 0;

  cmd_seq_player #(
    .NUM_CMDS(8), .CMD_W(16), .RESP_W(8), .ACK_VAL(8'hA5),
    .TIMEOUT_CLKS(24'd1000), .GAP_CLKS(18'd100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .num_cmds(num_cmds), .start(start), .abort(abort),
    .cmd(cmd), .snd_cmd(snd_cmd), .cmd_snt(cmd_snt), .resp_rdy(resp_rdy),
    .resp(resp), .busy(busy), .done(done), .pass(pass),
    .fail_code(fail_code), .fail_idx(fail_idx), .cmd_idx(cmd_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [IW-1:0]   n;
    int              dly;
    logic [7:0][7:0] rsp;
    bit              poke;
    int              e_sends;
    bit              e_pass;
    logic [1:0]      e_fc;
    logic [IW-1:0]   e_fi;
    logic [IW-1:0]   e_ci;
  } scn_t;

  scn_t v[8];

  function automatic logic [15:0] word(input int i);
    return 16'(32'h2000 + i * 32'h2001);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Responder: cmd_snt one cycle after each strobe, response dly cycles later,
  // and a spurious resp/cmd_snt inside the following gap that must be ignored.
  task automatic run_scn(input int k, input scn_t s);
    int t, sends, snt_at, rsp_at, spur_at, last_rsp;
    bit got;
    start = 1'b1; num_cmds = s.n;
    @(negedge clk);
    t = 0; sends = 0; snt_at = -1; rsp_at = -1; spur_at = -1; last_rsp = -1000; got = 1'b0;
    while (!got && t < 3000) begin
      cmd_snt = 1'b0; resp_rdy = 1'b0; resp = '0; ld_en = 1'b0; start = 1'b0;
      if (done) got = 1'b1;
      else begin
        if (snd_cmd) begin
          chk($sformatf("s%0d_cmd%0d", k, sends), 32'(cmd), 32'(word(sends)));
          chk($sformatf("s%0d_busy", k), 32'(busy), 32'd1);
          if (sends > 0) chk($sformatf("s%0d_gap", k), 32'(t - last_rsp >= 100), 32'd1);
          snt_at = t + 1; rsp_at = t + 1 + s.dly; sends++;
          if (s.poke && sends == 1) begin
            ld_en = 1'b1; ld_addr = 4'd1; ld_data = 16'hDEAD; start = 1'b1;
          end
        end
        if (t == snt_at) cmd_snt = 1'b1;
        if (t == rsp_at) begin
          resp_rdy = 1'b1; resp = s.rsp[sends-1]; last_rsp = t; spur_at = t + 3;
        end
        if (t == spur_at) begin resp_rdy = 1'b1; resp = 8'h00; cmd_snt = 1'b1; end
      end
      if (!got) begin @(negedge clk); t++; end
    end
    chk($sformatf("s%0d_done_seen", k), 32'(got), 32'd1);
    chk($sformatf("s%0d_sends", k), sends, s.e_sends);
    chk($sformatf("s%0d_pass", k), 32'(pass), 32'(s.e_pass));
    chk($sformatf("s%0d_fcode", k), 32'(fail_code), 32'(s.e_fc));
    chk($sformatf("s%0d_fidx", k), 32'(fail_idx), 32'(s.e_fi));
    chk($sformatf("s%0d_cidx", k), 32'(cmd_idx), 32'(s.e_ci));
    chk($sformatf("s%0d_busy_done", k), 32'(busy), 32'd0);
    @(negedge clk);
    chk($sformatf("s%0d_done_1cyc", k), 32'(done), 32'd0);
  endtask

  initial begin
    logic [7:0][7:0] ack8, rr;
    int t, nsnd, ndone;

    ack8 = {8{8'hA5}};
    //       n     dly rsp   poke  sends pass  fc    fi    ci
    v[0] = '{4'd1,  0, ack8, 1'b0, 1, 1'b1, 2'd0, 4'd0, 4'd0};
    v[1] = '{4'd3,  1, ack8, 1'b0, 3, 1'b1, 2'd0, 4'd0, 4'd2};
    rr = ack8; rr[1] = 8'h5A;
    v[2] = '{4'd3,  2, rr,   1'b0, 2, 1'b0, 2'd1, 4'd1, 4'd1};
    rr = ack8; rr[0] = 8'h00;
    v[3] = '{4'd2,  0, rr,   1'b0, 1, 1'b0, 2'd1, 4'd0, 4'd0};
    v[4] = '{4'd15, 1, ack8, 1'b0, 8, 1'b1, 2'd0, 4'd0, 4'd7};
    v[5] = '{4'd0,  0, ack8, 1'b0, 0, 1'b1, 2'd0, 4'd0, 4'd0};
    rr = ack8; rr[3] = 8'hA4;
    v[6] = '{4'd4,  3, rr,   1'b0, 4, 1'b0, 2'd1, 4'd3, 4'd3};
    v[7] = '{4'd2,  1, ack8, 1'b1, 2, 1'b1, 2'd0, 4'd0, 4'd1};

    // asynchronous reset before any clock edge
    #1 rst_n = 1'b0;
    #2;
    chk("rst_cmd", 32'(cmd), 32'd0);
    chk("rst_snd", 32'(snd_cmd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_fcode", 32'(fail_code), 32'd0);
    chk("rst_fidx", 32'(fail_idx), 32'd0);
    chk("rst_cidx", 32'(cmd_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // load the store; out-of-range addresses must not alias onto entry 0
    for (int i = 0; i < 8; i++) begin
      ld_en = 1'b1; ld_addr = 4'(i); ld_data = word(i);
      @(negedge clk);
    end
    ld_addr = 4'd8;  ld_data = 16'hBEEF; @(negedge clk);
    ld_addr = 4'd15; ld_data = 16'hBEEF; @(negedge clk);
    ld_en = 1'b0;

    for (int k = 0; k < 8; k++) run_scn(k, v[k]);

    // timeout: response withheld, done exactly 1000 cycles after snd_cmd
    num_cmds = 4'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("tmo_snd_lat", 32'(snd_cmd), 32'd1);
    t = 0;
    @(negedge clk); t = 1; cmd_snt = 1'b1;
    @(negedge clk); t = 2; cmd_snt = 1'b0;
    while (!done && t < 1100) begin
      @(negedge clk); t++;
      if (t == 500) chk("tmo_cmd_hold", 32'(cmd), 32'(word(0)));
    end
    chk("tmo_latency", t, 1000);
    chk("tmo_fcode", 32'(fail_code), 32'd2);
    chk("tmo_pass", 32'(pass), 32'd0);
    chk("tmo_fidx", 32'(fail_idx), 32'd0);
    @(negedge clk);

    // ack arriving in the expiry cycle wins over the timeout
    num_cmds = 4'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("exp_snd_lat", 32'(snd_cmd), 32'd1);
    t = 0;
    @(negedge clk); t = 1; cmd_snt = 1'b1;
    @(negedge clk); t = 2; cmd_snt = 1'b0;
    while (!done && t < 1100) begin
      @(negedge clk); t++;
      resp_rdy = (t == 999); resp = 8'hA5;
    end
    resp_rdy = 1'b0;
    chk("exp_latency", t, 1000);
    chk("exp_pass", 32'(pass), 32'd1);
    chk("exp_fcode", 32'(fail_code), 32'd0);
    @(negedge clk);

    // abort during the gap after the first ack
    num_cmds = 4'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("abt_snd", 32'(snd_cmd), 32'd1);
    @(negedge clk); cmd_snt = 1'b1;
    @(negedge clk); cmd_snt = 1'b0; resp_rdy = 1'b1; resp = 8'hA5;
    @(negedge clk); resp_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("abt_busy_gap", 32'(busy), 32'd1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abt_done", 32'(done), 32'd1);
    chk("abt_fcode", 32'(fail_code), 32'd3);
    chk("abt_fidx", 32'(fail_idx), 32'd0);
    chk("abt_pass", 32'(pass), 32'd0);
    nsnd = 0; ndone = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      nsnd += int'(snd_cmd); ndone += int'(done);
      cmd_snt = (i == 2); resp_rdy = (i == 4); resp = 8'hA5;
    end
    cmd_snt = 1'b0; resp_rdy = 1'b0;
    chk("abt_no_snd", nsnd, 0);
    chk("abt_no_done", ndone, 0);
    chk("abt_fcode_hold", 32'(fail_code), 32'd3);

    // abort while idle does nothing
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("idle_abt_done", 32'(done), 32'd0);
    chk("idle_abt_fcode", 32'(fail_code), 32'd3);

    // empty playback: done one cycle after start, no strobe
    num_cmds = 4'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("n0_done", 32'(done), 32'd1);
    chk("n0_snd", 32'(snd_cmd), 32'd0);
    chk("n0_pass", 32'(pass), 32'd1);
    chk("n0_fcode", 32'(fail_code), 32'd0);
    @(negedge clk);
    chk("n0_done_1cyc", 32'(done), 32'd0);

    // reset in WAIT_RESP clears outputs at once and the block stays idle
    num_cmds = 4'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); cmd_snt = 1'b1;
    @(negedge clk); cmd_snt = 1'b0;
    @(negedge clk);
    chk("rmid_busy", 32'(busy), 32'd1);
    chk("rmid_cmd", 32'(cmd), 32'(word(0)));
    #2 rst_n = 1'b0;
    #1;
    chk("rmid_cmd0", 32'(cmd), 32'd0);
    chk("rmid_busy0", 32'(busy), 32'd0);
    chk("rmid_flags0", 32'({snd_cmd, done, pass, fail_code}), 32'd0);
    chk("rmid_idx0", 32'({fail_idx, cmd_idx}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    nsnd = 0; ndone = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      nsnd += int'(snd_cmd) + int'(busy); ndone += int'(done);
      cmd_snt = (i == 3); resp_rdy = (i == 5); resp = 8'hA5;
    end
    cmd_snt = 1'b0; resp_rdy = 1'b0;
    chk("rpost_no_activity", nsnd, 0);
    chk("rpost_no_done", ndone, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
